// File: rtl/start_cond_pkg.sv
// Shared types and constants for the start conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package start_cond_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  // Width of a counter that must hold 0 .. cyc-1 (never narrower than 1 bit).
  function automatic int unsigned timer_w(input int unsigned cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/debouncer.sv
// Synchronizes the raw active-low button and debounces it into a clean pressed level.
// Latency: SYNC_STAGES + DEBOUNCE_CYC cycles from pin change to pressed change.
// Backpressure: none; free-running, glitches shorter than DEBOUNCE_CYC are dropped.
module debouncer #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pressed_q, pressed_d;
  logic                   key_level;

  // Shift the pin into the sync chain; count consecutive disagreeing cycles and
  // flip the accepted level once the disagreement has lasted DEBOUNCE_CYC cycles.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], key_n};
    key_level = ~sync_q[SYNC_STAGES-1];
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (key_level != pressed_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        pressed_d = key_level;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; the chain resets to "released" so a held key must re-debounce.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/start_conditioner.sv
// Turns a debounced button press into a level start/operand handshake for the algorithm block.
// Latency: press_evt to start is 1 cycle; pin to start is SYNC_STAGES+DEBOUNCE_CYC+1 cycles.
// Backpressure: start is held through the done phase until the button is released.
module start_conditioner
  import start_cond_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned TIMEOUT_CYC  = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              done,
  output logic              start,
  output logic [DATA_W-1:0] operand,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned TIMER_W = timer_w(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_q, sw_sync_d;
  logic [DATA_W-1:0]                  sw_sync;
  logic                               pressed, pressed_prev_q, pressed_prev_d;
  logic                               press_evt, rel;
  state_t                             state_q, state_d;
  logic [DATA_W-1:0]                  operand_q, operand_d;
  logic                               start_q, start_d;
  logic                               busy_q, busy_d;
  logic                               timeout_q, timeout_d;
  logic [TIMER_W-1:0]                 timer_q, timer_d;

  debouncer #(
    .SYNC_STAGES  (SYNC_STAGES),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debouncer (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .pressed (pressed)
  );

  // Switch synchronizer and edge detector on the debounced level.
  always_comb begin
    sw_sync_d      = {sw_sync_q[SYNC_STAGES-2:0], sw_in};
    sw_sync        = sw_sync_q[SYNC_STAGES-1];
    pressed_prev_d = pressed;
    press_evt      = pressed & ~pressed_prev_q;
    rel            = ~pressed;
  end

  // Next-state and registered-output logic; done beats the timer in RUN.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    timeout_d = timeout_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE: begin
        operand_d = sw_sync;
        if (press_evt) begin
          state_d   = RUN;
          timeout_d = 1'b0;
          timer_d   = '0;
        end
      end
      RUN: begin
        if (done) begin
          state_d = HOLD;
        end else if (timer_q == TIMER_W'(TIMEOUT_CYC - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        if (rel) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d != IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers; reset drops start/busy immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_sync_q      <= '0;
      pressed_prev_q <= 1'b0;
      state_q        <= IDLE;
      operand_q      <= '0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      timeout_q      <= 1'b0;
      timer_q        <= '0;
    end else begin
      sw_sync_q      <= sw_sync_d;
      pressed_prev_q <= pressed_prev_d;
      state_q        <= state_d;
      operand_q      <= operand_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      timeout_q      <= timeout_d;
      timer_q        <= timer_d;
    end
  end

  assign start   = start_q;
  assign busy    = busy_q;
  assign operand = operand_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_start_conditioner.sv
// Directed bench: expected start edges are queued by the stimulus, a negedge monitor pops them.
// Latency under test: pin to start = SYNC_STAGES+DEBOUNCE_CYC+1 = 7 cycles here.
// Backpressure: n/a.
module tb_start_conditioner;

  localparam int LAT = 7;  // 2 sync + 4 debounce + 1 launch

  logic       clk;
  logic       reset;
  logic       key_n;
  logic [7:0] sw_in;
  logic       done;
  logic       start;
  logic [7:0] operand;
  logic       busy;
  logic       timeout;

  typedef struct {
    bit         st;
    logic [7:0] op;
    bit         to;
    int         cy;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  bit   start_seen;

  start_conditioner #(
    .DATA_W       (8),
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (4),
    .TIMEOUT_CYC  (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .sw_in   (sw_in),
    .done    (done),
    .start   (start),
    .operand (operand),
    .busy    (busy),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of start is a DUT event and must match the next queued record.
  always @(negedge clk) begin
    if (start != start_seen) begin
      exp_t e;
      start_seen = start;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start_edge: start=%0b at cyc %0d, none expected", start, cyc);
      end else begin
        e = exp_q.pop_front();
        if (start !== e.st || busy !== e.st || operand !== e.op || timeout !== e.to || cyc != e.cy) begin
          errors++;
          $display("FAIL start_edge: got start=%0b busy=%0b op=%02h to=%0b cyc=%0d, expected start=%0b busy=%0b op=%02h to=%0b cyc=%0d",
                   start, busy, operand, timeout, cyc, e.st, e.st, e.op, e.to, e.cy);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push(input bit st, input logic [7:0] op, input bit to, input int cy);
    exp_t e;
    e.st = st;
    e.op = op;
    e.to = to;
    e.cy = cy;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial begin
    int p;
    int s;
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    start_seen = 1'b0;
    reset      = 1'b0;
    key_n      = 1'b1;
    sw_in      = 8'h00;
    done       = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_operand", operand, 0);
    check("rst_timeout", timeout, 0);
    reset = 1'b1;
    sw_in = 8'hA5;
    repeat (5) tick();
    check("idle_operand", operand, 8'hA5);

    // 1: normal press, done after 5 RUN cycles, release
    p = cyc;
    key_n = 1'b0;
    push(1'b1, 8'hA5, 1'b0, p + LAT);
    wait_cyc(p + 10); key_n = 1'b1;
    wait_cyc(p + 12); check("t1_busy_run", busy, 1); done = 1'b1;
    wait_cyc(p + 13); done = 1'b0;
    push(1'b0, 8'hA5, 1'b0, p + 17);
    wait_cyc(p + 25);

    // 2: short glitches never launch; operand keeps tracking switches
    for (int i = 0; i < 3; i++) begin
      logic [7:0] v;
      v = 8'h11 * (i + 1);
      sw_in = v;
      key_n = 1'b0;
      repeat (3) tick();
      key_n = 1'b1;
      repeat (4) tick();
      check("t2_operand_tracks", operand, v);
      check("t2_no_start", start, 0);
    end
    repeat (6) tick();
    check("t2_no_start_end", start, 0);

    // 3: switch change during RUN is ignored until back in IDLE
    sw_in = 8'hA5;
    repeat (5) tick();
    p = cyc;
    key_n = 1'b0;
    push(1'b1, 8'hA5, 1'b0, p + LAT);
    wait_cyc(p + 9);  sw_in = 8'h3C;
    wait_cyc(p + 10); key_n = 1'b1;
    wait_cyc(p + 12); check("t3_operand_frozen", operand, 8'hA5);
    wait_cyc(p + 14); done = 1'b1;
    wait_cyc(p + 15); done = 1'b0;
    push(1'b0, 8'hA5, 1'b0, p + 17);
    wait_cyc(p + 22); check("t3_operand_new", operand, 8'h3C);

    // 4: done never comes -> timeout after 16 RUN cycles
    sw_in = 8'h77;
    repeat (5) tick();
    p = cyc;
    key_n = 1'b0;
    push(1'b1, 8'h77, 1'b0, p + LAT);
    wait_cyc(p + 10); key_n = 1'b1;
    wait_cyc(p + 22); check("t4_still_run", start, 1);
    push(1'b0, 8'h77, 1'b1, p + LAT + 16);
    wait_cyc(p + 30);
    check("t4_timeout_sticky", timeout, 1);
    check("t4_start_low", start, 0);

    // 5: release before done; relaunch clears timeout; HOLD lasts one cycle
    sw_in = 8'hC3;
    repeat (5) tick();
    p = cyc;
    key_n = 1'b0;
    push(1'b1, 8'hC3, 1'b0, p + LAT);
    wait_cyc(p + 8);  check("t5_timeout_cleared", timeout, 0); key_n = 1'b1;
    wait_cyc(p + 16); done = 1'b1;
    wait_cyc(p + 17); done = 1'b0; check("t5_hold_start", start, 1);
    push(1'b0, 8'hC3, 1'b0, p + 18);
    wait_cyc(p + 24);

    // 6: reset mid-RUN, key held through release of reset
    sw_in = 8'h96;
    repeat (5) tick();
    p = cyc;
    key_n = 1'b0;
    push(1'b1, 8'h96, 1'b0, p + LAT);
    wait_cyc(p + 10);
    push(1'b0, 8'h00, 1'b0, p + 10);
    reset = 1'b0;
    #1;
    check("t6_rst_start", start, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_operand", operand, 0);
    check("t6_rst_timeout", timeout, 0);
    wait_cyc(p + 12);
    s = cyc;
    reset = 1'b1;
    push(1'b1, 8'h96, 1'b0, s + LAT);
    wait_cyc(s + LAT - 1); check("t6_no_early_launch", start, 0);
    wait_cyc(s + 9);  key_n = 1'b1;
    wait_cyc(s + 10); done = 1'b1;
    wait_cyc(s + 11); done = 1'b0;
    push(1'b0, 8'h96, 1'b0, s + 16);
    wait_cyc(s + 25);

    check("all_events_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
